// File: rtl/exec_sequencer.sv
// exec_sequencer
// Multi-cycle fetch / decode / operand-read / execute sequencer for the
// register-register ALU unit. Owns the program counter and the retired count.
//
// Build option: define SEQ_ILLEGAL_TRAP_EN to stop the core in a TRAP state
// on an unknown major opcode (sticky illegal + halt). Without it, unknown
// opcodes retire as NOPs and illegal is tied low.
module exec_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            alu_reg_enable_n,
  output logic            rf_we,
  output logic            halt,
  output logic            illegal,
  output logic [XLEN-1:0] retired
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

`ifdef SEQ_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_TRAP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;
`endif

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_retired;
  // Output flags are registered alongside the state transition that
  // produces them, so each reflects the state being entered.
  logic            r_req;
  logic            r_en_n;
  logic            r_we;
  logic            r_halt;
`ifdef SEQ_ILLEGAL_TRAP_EN
  logic            r_illegal;
`endif

  logic [6:0]      w_opcode;

  assign w_opcode = r_ir[6:0];

  // Sequencer FSM: state, PC, IR, retired count and registered control flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_retired <= '0;
      r_req     <= 1'b1;
      r_en_n    <= 1'b1;
      r_we      <= 1'b0;
      r_halt    <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
            r_req   <= 1'b0;
          end
        end

        S_DECODE: begin
          if (w_opcode == OPC_OP) begin
            r_state <= S_READ;
            r_en_n  <= 1'b0;
          end else if (w_opcode == OPC_SYSTEM) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
          end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            // PC keeps the offending address for post-mortem inspection.
            r_state   <= S_TRAP;
            r_halt    <= 1'b1;
            r_illegal <= 1'b1;
`else
            // Unknown opcode retires as a NOP straight back to fetch.
            r_pc      <= r_pc + PC_STEP;
            r_retired <= r_retired + 1'b1;
            r_state   <= S_FETCH;
            r_req     <= 1'b1;
`endif
          end
        end

        S_READ: begin
          // ALU unit captured its register selects; next cycle writes back.
          r_state <= S_EXEC;
          r_we    <= 1'b1;
        end

        S_EXEC: begin
          r_pc      <= r_pc + PC_STEP;
          r_retired <= r_retired + 1'b1;
          r_state   <= S_FETCH;
          r_req     <= 1'b1;
          r_en_n    <= 1'b1;
          r_we      <= 1'b0;
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

`ifdef SEQ_ILLEGAL_TRAP_EN
        S_TRAP: begin
          r_state <= S_TRAP;
        end
`endif

        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_en_n  <= 1'b1;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are qualified by rst: no request in a reset cycle, and a write
  // caught mid-EXEC by reset is dropped.
  assign imem_req         = r_req & ~rst;
  assign alu_reg_enable_n = r_en_n | rst;
  assign rf_we            = r_we & ~rst;

  assign imem_addr   = r_pc;
  assign instruction = r_ir;
  assign retired     = r_retired;
  assign halt        = r_halt;
`ifdef SEQ_ILLEGAL_TRAP_EN
  assign illegal     = r_illegal;
`else
  assign illegal     = 1'b0;
`endif

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM that fetches instructions, decodes the major opcode, and sequences the register-register ALU execution unit through its operand-read and execute cycles. Sits between instruction memory, the R-type ALU unit (driven through its active-low enable), and the register-file write port. Owns the program counter and a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; synchronous and active-high.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  XLEN  fetch address (current PC).
- imem_ack  in  1  fetch acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  XLEN  fetched instruction word.
- instruction  out  XLEN  latched instruction register, broadcast to execution units.
- alu_reg_enable_n  out  1  active-low enable for the R-type ALU unit.
- rf_we  out  1  register-file write strobe for the ALU result.
- halt  out  1  core stopped on a SYSTEM instruction, or on a trap when enabled.
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  XLEN  count of completed instructions.

## Operation
- States: FETCH, DECODE, READ, EXEC, HALT, TRAP.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_ack: IR<=imem_rdata, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle), based on IR[6:0]:
  - 7'b0110011 (OP): go to READ.
  - 7'b1110011 (SYSTEM): go to HALT.
  - Any other value: illegal; see Configuration.
- READ:
  - alu_reg_enable_n=0; the unit registers its register selects at this edge.
  - Go to EXEC.
- EXEC:
  - alu_reg_enable_n=0 and rf_we=1; the write commits at the end of the cycle.
  - PC<=PC+4 and retired<=retired+1, then go to FETCH.
- HALT: halt=1, PC frozen; terminal until rst.
- Outside READ and EXEC: alu_reg_enable_n=1 and rf_we=0.
- Arithmetic: PC and retired wrap modulo 2^XLEN (32'hFFFF_FFFC+4 = 0). The PC is never misaligned.
- rf_we is asserted regardless of the rd value; the register file owns the x0 discard.

## Timing
- Reset values:
  - state=FETCH, PC=RESET_PC, IR=0.
  - imem_req=0 during the reset cycle.
  - alu_reg_enable_n=1, rf_we=0, halt=0, illegal=0, retired=0.
- imem_req rises in the first cycle after rst deasserts.
- The ack may arrive in the same cycle as req; the minimum fetch is 1 cycle.
- R-type latency, ack cycle to next imem_req=1: 3 cycles (DECODE, READ, EXEC). Minimum throughput is one instruction per 4 cycles.
- imem_addr is stable while imem_req=1. The PC changes only at the EXEC exit edge, or at the DECODE exit edge for a NOP'd illegal instruction.
- rst asserted mid-operation (any state, including an outstanding fetch):
  - All state returns to reset values the next edge.
  - The pending request is abandoned; a late imem_ack is ignored.
  - A write in progress in EXEC is suppressed (rf_we=0).
- rst has priority over imem_ack in the same cycle.
- retired and rf_we update on the same edge.

## Configuration
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined, illegal opcode in DECODE:
  - Go to TRAP: illegal=1 and halt=1, both sticky until rst.
  - PC holds the offending instruction's address; retired is not incremented.
- Undefined, illegal opcode in DECODE:
  - Treated as a NOP: PC<=PC+4, retired+1, back to FETCH.
  - illegal is tied 0 and the TRAP state does not exist.

## Test plan
- Reset then ack-in-same-cycle with an ADD word (IR[6:0]=0110011) at PC 0 -> enable_n low exactly 2 cycles, rf_we high 1 cycle (EXEC), next imem_addr=4, retired=1.
- Ack delayed 5 cycles -> imem_req held high with imem_addr constant all 5 cycles; no enable or write pulses during the wait.
- Word 32'h0000_0073 (ECALL) at PC 8 -> halt=1 the cycle after DECODE; no further imem_req for 20 cycles; PC stays 8.
- Opcode 7'b0000000 with SEQ_ILLEGAL_TRAP_EN defined -> illegal=1, halt=1, PC unchanged. With the macro undefined -> next fetch at PC+4, retired+1, illegal=0.
- RESET_PC=32'hFFFF_FFFC, one R-type instruction -> next imem_addr=0, retired=1.
- rst pulsed during EXEC -> rf_we=0 in that cycle; next edge shows PC=RESET_PC, retired=0; a late imem_ack is ignored.
